riscv_aes_fetch: RTL and testbench

- Read-side counterpart of the AES writeback path.
- On a start pulse, fetches four consecutive 32-bit words from data memory over a req/gnt/rvalid interface and assembles them into one 128-bit AES operand block.
- Holds the core halted while the fetch is in progress, then presents the block with a one-cycle valid pulse.
- Sits between the core's AES instruction decode and the LSU data port, ahead of the AES engine.

---
 rtl/riscv_aes_pkg.sv | 17 +
 rtl/riscv_aes_fetch_if.sv | 29 ++
 rtl/riscv_aes_fetch.sv | 100 ++++++++++
 tb/tb_riscv_aes_fetch.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_aes_pkg.sv
// riscv_aes_pkg: constants and state encoding shared by the AES fetch and writeback paths.
// Ports: none (package).
// Block width, word width and address stride all live here so both directions stay in step.
package riscv_aes_pkg;

  localparam int AES_BLOCK_W     = 128;
  localparam int AES_WORD_W      = 32;
  localparam int AES_ADDR_STRIDE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } aes_fetch_state_e;

endpackage

// File: rtl/riscv_aes_fetch_if.sv
// riscv_aes_fetch_if: LSU data-port read channel (req/gnt/rvalid) used by the AES fetch block.
// Ports: data_req_out/data_addr_out from the fetch side; data_gnt_in/data_rvalid_in/data_rdata_in from memory.
// master = AES fetch block, slave = memory / LSU.
interface riscv_aes_fetch_if;
  import riscv_aes_pkg::*;

  logic                  data_req_out;
  logic [31:0]           data_addr_out;
  logic                  data_gnt_in;
  logic                  data_rvalid_in;
  logic [AES_WORD_W-1:0] data_rdata_in;

  modport master (
    output data_req_out,
    output data_addr_out,
    input  data_gnt_in,
    input  data_rvalid_in,
    input  data_rdata_in
  );

  modport slave (
    input  data_req_out,
    input  data_addr_out,
    output data_gnt_in,
    output data_rvalid_in,
    output data_rdata_in
  );

endinterface

// File: rtl/riscv_aes_fetch.sv
// riscv_aes_fetch: reads NUM_WORDS consecutive words from data memory into one AES operand block.
// Ports: clk, rst (sync, active-high); start_aes_fetch/address_in from decode; mem (read channel master);
//        halt_en_out stalls the core during the fetch; data_valid_out pulses once with data_out complete.
module riscv_aes_fetch
  import riscv_aes_pkg::*;
#(
  parameter int NUM_WORDS   = AES_BLOCK_W / AES_WORD_W,
  parameter int ADDR_STRIDE = AES_ADDR_STRIDE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_aes_fetch,
  input  logic [31:0]                     address_in,
  riscv_aes_fetch_if.master               mem,
  output logic                            halt_en_out,
  output logic                            data_valid_out,
  output logic [NUM_WORDS*AES_WORD_W-1:0] data_out
);

  localparam int              CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

  aes_fetch_state_e state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      base;
  logic             req;
  logic [31:0]      addr;

  // Word address relative to the latched base; 32-bit overflow wraps silently.
  function automatic logic [31:0] word_addr(input logic [31:0] b, input logic [CNT_W-1:0] idx);
    return b + 32'(idx) * 32'(ADDR_STRIDE);
  endfunction

  // Every output is a register, so nothing from the memory side or decode
  // reaches an output combinationally. req/addr are loaded one cycle ahead,
  // on the transition into REQ, so they are valid for the whole REQ cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      base           <= '0;
      data_out       <= '0;
      req            <= 1'b0;
      addr           <= '0;
      halt_en_out    <= 1'b0;
      data_valid_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_aes_fetch) begin
            base        <= address_in;
            cnt         <= '0;
            addr        <= address_in;
            req         <= 1'b1;
            halt_en_out <= 1'b1;
            state       <= REQ;
          end
        end

        // Address stays parked until the grant arrives.
        REQ: begin
          if (mem.data_gnt_in) begin
            req   <= 1'b0;
            state <= WAIT;
          end
        end

        // Single outstanding read: the next request is only issued once this
        // word has returned.
        WAIT: begin
          if (mem.data_rvalid_in) begin
            data_out[cnt*AES_WORD_W +: AES_WORD_W] <= mem.data_rdata_in;
            if (cnt == LAST) begin
              data_valid_out <= 1'b1;
              state          <= DONE;
            end else begin
              cnt   <= cnt + 1'b1;
              addr  <= word_addr(base, cnt + 1'b1);
              req   <= 1'b1;
              state <= REQ;
            end
          end
        end

        // Valid is high for this one cycle; halt drops with it.
        DONE: begin
          data_valid_out <= 1'b0;
          halt_en_out    <= 1'b0;
          state          <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign mem.data_req_out  = req;
  assign mem.data_addr_out = addr;

endmodule

// File: tb/tb_riscv_aes_fetch.sv
// tb_riscv_aes_fetch: directed, table-driven bench for riscv_aes_fetch.
// Ports: none; drives the DUT through a riscv_aes_fetch_if instance.
// Per-cycle vector rows for best-case fetches, hand sequences for stalls and reset.
module tb_riscv_aes_fetch;

  logic         clk;
  logic         rst;
  logic         start;
  logic [31:0]  addr_in;
  logic         halt;
  logic         valid;
  logic [127:0] dout;

  riscv_aes_fetch_if mem_if ();

  riscv_aes_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .start_aes_fetch (start),
    .address_in      (addr_in),
    .mem             (mem_if),
    .halt_en_out     (halt),
    .data_valid_out  (valid),
    .data_out        (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One row per clock cycle: inputs driven in that cycle and the outputs
  // expected during that same cycle.
  typedef struct {
    logic         start;
    logic [31:0]  addr_in;
    logic         gnt;
    logic         rvalid;
    logic [31:0]  rdata;
    logic         e_req;
    logic [31:0]  e_addr;
    logic         e_halt;
    logic         e_valid;
    logic [127:0] e_data;
  } vec_t;

  vec_t         vecs[$];
  logic [127:0] mdl;  // expected contents of data_out while building rows

  task automatic add(input logic st, input logic [31:0] ai, input logic g, input logic rv,
                     input logic [31:0] rd, input logic er, input logic [31:0] ea,
                     input logic eh, input logic ev);
    vec_t v;
    v.start = st;  v.addr_in = ai; v.gnt = g; v.rvalid = rv; v.rdata = rd;
    v.e_req = er;  v.e_addr = ea;  v.e_halt = eh; v.e_valid = ev; v.e_data = mdl;
    vecs.push_back(v);
  endtask

  // Best-case fetch: start row, 4 x (REQ with gnt, WAIT with rvalid), DONE row.
  // With spur set, stray gnt/rvalid/start are injected where they must be ignored.
  task automatic push_fetch(input logic [31:0] base, input logic [127:0] blk, input logic spur);
    add(1'b1, base, spur, spur, 32'hBAD0_0000, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      add(1'b0, 32'h0, 1'b1, spur, 32'hBAD0_0001, 1'b1, base + 32'(4 * i), 1'b1, 1'b0);
      add(spur, 32'hDEAD_0000, spur, 1'b1, blk[i*32 +: 32], 1'b0, 32'h0, 1'b1, 1'b0);
      mdl[i*32 +: 32] = blk[i*32 +: 32];
    end
    add(spur, 32'hDEAD_0000, spur, spur, 32'hBAD0_0002, 1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic push_idle(input int n, input logic spur);
    for (int i = 0; i < n; i++)
      add(1'b0, 32'h0, spur, spur, 32'hBAD0_0003, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Fetch with optional grant delay on word gdw and rvalid delay on word rdw;
  // checks req/addr stability through the stalls and the total latency.
  task automatic fetch_custom(input string tag, input logic [31:0] base, input logic [127:0] blk,
                              input int gdw, input int gd, input int rdw, input int rd,
                              input int exp_lat);
    int t0;
    int g;
    int r;
    @(negedge clk);
    chk({tag, " idle halt"}, 128'(halt), 128'(0));
    start = 1'b1; addr_in = base; t0 = cyc;
    @(negedge clk);
    start = 1'b0; addr_in = 32'h0;
    for (int i = 0; i < 4; i++) begin
      g = (i == gdw) ? gd : 0;
      r = (i == rdw) ? rd : 0;
      for (int d = 0; d <= g; d++) begin
        chk($sformatf("%s w%0d c%0d req", tag, i, d), 128'(mem_if.data_req_out), 128'(1));
        chk($sformatf("%s w%0d c%0d addr", tag, i, d), 128'(mem_if.data_addr_out), 128'(base + 32'(4 * i)));
        chk($sformatf("%s w%0d c%0d halt", tag, i, d), 128'(halt), 128'(1));
        mem_if.data_gnt_in = (d == g);
        @(negedge clk);
        mem_if.data_gnt_in = 1'b0;
      end
      for (int d = 0; d <= r; d++) begin
        chk($sformatf("%s w%0d r%0d req", tag, i, d), 128'(mem_if.data_req_out), 128'(0));
        chk($sformatf("%s w%0d r%0d halt", tag, i, d), 128'(halt), 128'(1));
        mem_if.data_rvalid_in = (d == r);
        mem_if.data_rdata_in  = (d == r) ? blk[i*32 +: 32] : 32'hBAD0_0004;
        @(negedge clk);
        mem_if.data_rvalid_in = 1'b0;
      end
    end
    chk({tag, " done valid"}, 128'(valid), 128'(1));
    chk({tag, " done halt"}, 128'(halt), 128'(1));
    chk({tag, " done data"}, dout, blk);
    chk({tag, " latency"}, 128'(cyc - t0), 128'(exp_lat));
    @(negedge clk);
    chk({tag, " post valid"}, 128'(valid), 128'(0));
    chk({tag, " post halt"}, 128'(halt), 128'(0));
  endtask

  localparam logic [127:0] BLK1 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  localparam logic [127:0] BLK2 = {32'hD0D0_D0D0, 32'hC0C0_C0C0, 32'hB0B0_B0B0, 32'hA0A0_A0A0};
  localparam logic [127:0] BLK3 = {32'h8888_0003, 32'h7777_0002, 32'h6666_0001, 32'h5555_0000};
  localparam logic [127:0] BLKB = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
  localparam logic [127:0] BLKR = {32'h0BAD_F00D, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F};

  initial begin
    rst = 1'b1; start = 1'b0; addr_in = 32'h0;
    mem_if.data_gnt_in = 1'b0; mem_if.data_rvalid_in = 1'b0; mem_if.data_rdata_in = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst req",   128'(mem_if.data_req_out),  128'(0));
    chk("rst addr",  128'(mem_if.data_addr_out), 128'(0));
    chk("rst halt",  128'(halt),  128'(0));
    chk("rst valid", 128'(valid), 128'(0));
    chk("rst data",  dout, 128'(0));
    rst = 1'b0;

    // Build rows: basic fetch, address wrap followed back-to-back by base 0x2000,
    // then a fetch with stray start/gnt/rvalid everywhere they must be ignored.
    mdl = '0;
    push_fetch(32'h0000_1000, BLK1, 1'b0);
    push_idle(1, 1'b0);
    push_fetch(32'hFFFF_FFF8, BLK2, 1'b0);
    push_fetch(32'h0000_2000, BLK3, 1'b0);
    push_idle(1, 1'b0);
    push_idle(2, 1'b1);
    push_fetch(32'h0000_1000, BLK1, 1'b1);
    push_idle(3, 1'b1);

    foreach (vecs[k]) begin
      @(negedge clk);
      chk($sformatf("row%0d req", k),   128'(mem_if.data_req_out), 128'(vecs[k].e_req));
      if (vecs[k].e_req)
        chk($sformatf("row%0d addr", k), 128'(mem_if.data_addr_out), 128'(vecs[k].e_addr));
      chk($sformatf("row%0d halt", k),  128'(halt),  128'(vecs[k].e_halt));
      chk($sformatf("row%0d valid", k), 128'(valid), 128'(vecs[k].e_valid));
      chk($sformatf("row%0d data", k),  dout, vecs[k].e_data);
      start                 = vecs[k].start;
      addr_in               = vecs[k].addr_in;
      mem_if.data_gnt_in    = vecs[k].gnt;
      mem_if.data_rvalid_in = vecs[k].rvalid;
      mem_if.data_rdata_in  = vecs[k].rdata;
    end
    @(negedge clk);
    start = 1'b0; addr_in = 32'h0;
    mem_if.data_gnt_in = 1'b0; mem_if.data_rvalid_in = 1'b0; mem_if.data_rdata_in = 32'h0;

    // Backpressure: grant 3 cycles late on word 1, rvalid 2 cycles late on word 2.
    fetch_custom("bp", 32'h0000_1000, BLKB, 1, 3, 2, 2, 14);

    // Reset while waiting for word 1.
    @(negedge clk);
    start = 1'b1; addr_in = 32'h0000_3000;
    @(negedge clk);
    start = 1'b0; addr_in = 32'h0; mem_if.data_gnt_in = 1'b1;
    @(negedge clk);
    mem_if.data_gnt_in = 1'b0; mem_if.data_rvalid_in = 1'b1; mem_if.data_rdata_in = 32'hAAAA_0000;
    @(negedge clk);
    chk("mid addr w1", 128'(mem_if.data_addr_out), 128'(32'h0000_3004));
    chk("mid partial data", dout, {BLKB[127:32], 32'hAAAA_0000});
    mem_if.data_rvalid_in = 1'b0; mem_if.data_gnt_in = 1'b1;
    @(negedge clk);
    mem_if.data_gnt_in = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst req",   128'(mem_if.data_req_out),  128'(0));
    chk("mrst addr",  128'(mem_if.data_addr_out), 128'(0));
    chk("mrst halt",  128'(halt),  128'(0));
    chk("mrst valid", 128'(valid), 128'(0));
    chk("mrst data",  dout, 128'(0));
    mem_if.data_rvalid_in = 1'b1; mem_if.data_rdata_in = 32'hBAD0_0005;
    @(negedge clk);
    mem_if.data_rvalid_in = 1'b0;
    chk("stale rv data", dout, 128'(0));
    chk("stale rv req",  128'(mem_if.data_req_out), 128'(0));
    chk("stale rv halt", 128'(halt), 128'(0));
    fetch_custom("post rst", 32'h0000_3000, BLKR, -1, 0, -1, 0, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
